// File: rtl/dff_if.sv
// Data/load bundle for the dff register: the master drives d and ld,
// the slave (the register) returns q.
interface dff_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic             ld;
  logic [WIDTH-1:0] q;

  modport master (output d, output ld, input  q);
  modport slave  (input  d, input  ld, output q);
endinterface

// File: rtl/dff.sv
// Load-enabled register with synchronous active-high reset.
// Ports keep the order d, rst, ld, clk, q so that positional instantiation
// dff(d, rst, ld, clk, q) works; rst may be tied low for a plain
// load-enabled flop.
module dff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] d,
  input  logic             rst,
  input  logic             ld,
  input  logic             clk,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Storage flop: reset beats load, load beats hold; only the rising edge matters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      r_q <= RESET_VALUE;
    end else if (ld) begin
      r_q <= d;
    end
  end

  // q comes straight from the flop; no input reaches it combinationally.
  assign q = r_q;

endmodule

// File: tb/tb_dff.sv
// Self-checking bench for dff: a 1-bit instance and a 10-bit instance with a
// non-zero reset value, driven by directed steps and then random traffic,
// compared against a behavioural model of the register rules.
module tb_dff;

  localparam logic [9:0] RV10 = 10'h155;

  logic clk = 1'b0;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the value each register should hold right now.
  logic [9:0] exp1;
  logic [9:0] exp10;

  dff_if #(.WIDTH(1))  if1 ();
  dff_if #(.WIDTH(10)) if10 ();

  dff #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dff1 (
    .d   (if1.d),
    .rst (rst),
    .ld  (if1.ld),
    .clk (clk),
    .q   (if1.q)
  );

  dff #(.WIDTH(10), .RESET_VALUE(RV10)) u_dff10 (
    .d   (if10.d),
    .rst (rst),
    .ld  (if10.ld),
    .clk (clk),
    .q   (if10.q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic l1, input logic d1,
                       input logic l10, input logic [9:0] d10);
    rst     = r;
    if1.ld  = l1;
    if1.d   = d1;
    if10.ld = l10;
    if10.d  = d10;
  endtask

  // Model rule for one edge: reset value, else captured data, else unchanged.
  function automatic logic [9:0] next_val(input logic [9:0] cur, input logic r,
                                          input logic l, input logic [9:0] dv,
                                          input logic [9:0] rv);
    if (r)      return rv;
    else if (l) return dv;
    else        return cur;
  endfunction

  // One rising edge: update the model from the inputs present at the edge,
  // then compare both registers 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    exp1  = next_val(exp1,  rst, if1.ld,  {9'b0, if1.d}, 10'h000);
    exp10 = next_val(exp10, rst, if10.ld, if10.d,        RV10);
    #1;
    check({tag, "/w1"},  {9'b0, if1.q}, exp1);
    check({tag, "/w10"}, if10.q,        exp10);
  endtask

  initial begin
    exp1  = 'x;
    exp10 = 'x;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
    #1;

    // Reset wins over a simultaneous load.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 10'h3FF);
    tick("reset_over_load");

    // First load right after reset release, no recovery cycle.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 10'h2AA);
    tick("load_after_reset");

    // Hold for three edges with ld low and d changed.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
    for (int i = 0; i < 3; i++) tick("hold");

    // Load 0 over a stored 1, then toggle d every edge.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 10'h0F0);
    tick("load_zero");
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, ~if1.d, 1'b1, ~if10.d);
      tick("toggle");
    end

    // Store 1 / 0x3C3, then a reset pulse that ends before the edge.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 10'h3C3);
    tick("preload");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    check("glitch_mid/w1",  {9'b0, if1.q}, exp1);
    check("glitch_mid/w10", if10.q,        exp10);
    tick("async_rst_pulse");

    // d wiggles between edges with ld high; only the value at the edge counts.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 10'h001);
    #2 begin if1.d = 1'b1; if10.d = 10'h3FE; end
    #2 begin if1.d = 1'b0; if10.d = 10'h155; end
    #1 begin if1.d = 1'b1; if10.d = 10'h0AB; end
    check("d_wiggle_mid/w1",  {9'b0, if1.q}, exp1);
    check("d_wiggle_mid/w10", if10.q,        exp10);
    tick("d_wiggle_edge");

    // Reset alone, then the 10-bit pattern load.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 10'h2AA);
    tick("reset_only");
    drive(1'b0, 1'b1, 1'b1, 1'b1, 10'h2AA);
    tick("load_2aa");

    // Random traffic: occasional reset, independent load enables.
    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 7) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), 10'($urandom));
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
